// File: rtl/timer_pkg.sv
// Shared constants for the interval timer: FSM state encoding, register map and
// CTRL/STATUS bit positions.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } timer_state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_START    = 0;
    localparam int CTRL_STOP     = 1;
    localparam int CTRL_MODE     = 2;
    localparam int CTRL_IRQ_MASK = 3;

    localparam int STATUS_RUNNING = 0;
    localparam int STATUS_DONE    = 1;

endpackage

// File: rtl/timer_prescaler.sv
// Wrap counter that counts 0..MAX while enabled, with a synchronous clear and a
// one-cycle registered pulse in the cycle after each wrap.
module timer_prescaler #(
    parameter int WIDTH = 17,
    parameter int MAX   = 99999
) (
    input  logic CLK,
    input  logic RESET,
    input  logic enable,
    input  logic clear,
    output logic at_wrap,
    output logic wrap_pulse
);

    localparam logic [WIDTH-1:0] MAX_VALUE = WIDTH'(MAX);

    logic [WIDTH-1:0] count;

    // at_wrap lets the owner act on the wrap edge itself; wrap_pulse trails it by one cycle
    assign at_wrap = enable && (count == MAX_VALUE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count      <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= at_wrap;
            if (clear || at_wrap) begin
                count <= '0;
            end else if (enable) begin
                count <= count + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Bus-programmable interval timer: register bank, control FSM and down-counter around a
// prescaler. Define TIMER_IRQ_EN to enable the masked level interrupt (CTRL[3]).
module interval_timer_ctrl
    import timer_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 17,
    parameter int PRESCALE_MAX   = 99999,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [1:0]             BUS_ADDR,
    input  logic                   BUS_WE,
    input  logic [COUNT_WIDTH-1:0] BUS_DATA_IN,
    output logic [COUNT_WIDTH-1:0] BUS_DATA_OUT,
    output logic                   TICK_OUT,
    output logic                   EXPIRE_OUT,
    output logic                   RUNNING,
    output logic                   IRQ
);

    timer_state_t           state;
    logic [COUNT_WIDTH-1:0] period_reg;
    logic [COUNT_WIDTH-1:0] count_reg;
    logic                   mode_reg;
    logic                   done_reg;
    logic                   running_reg;
    logic                   expire_reg;

    logic ctrl_wr;
    logic period_wr;
    logic status_wr;
    logic start_cmd;
    logic stop_cmd;
    logic done_clear;
    logic tick_now;
    logic psc_enable;
    logic psc_clear;

    assign ctrl_wr    = BUS_WE && (BUS_ADDR == ADDR_CTRL);
    assign period_wr  = BUS_WE && (BUS_ADDR == ADDR_PERIOD);
    assign status_wr  = BUS_WE && (BUS_ADDR == ADDR_STATUS);
    assign start_cmd  = ctrl_wr && BUS_DATA_IN[CTRL_START];
    assign stop_cmd   = ctrl_wr && BUS_DATA_IN[CTRL_STOP];
    assign done_clear = status_wr && BUS_DATA_IN[STATUS_DONE];

    // A START or STOP write pre-empts any tick that would land on the same edge
    assign psc_enable = (state == ST_RUN) && !start_cmd && !stop_cmd;
    assign psc_clear  = (state == ST_LOAD);

    timer_prescaler #(
        .WIDTH (PRESCALE_WIDTH),
        .MAX   (PRESCALE_MAX)
    ) u_prescaler (
        .CLK        (CLK),
        .RESET      (RESET),
        .enable     (psc_enable),
        .clear      (psc_clear),
        .at_wrap    (tick_now),
        .wrap_pulse (TICK_OUT)
    );

    // Control FSM; a DONE set from expiry is written after the clear so it wins a race
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= ST_IDLE;
            period_reg  <= '0;
            count_reg   <= '0;
            mode_reg    <= 1'b0;
            done_reg    <= 1'b0;
            running_reg <= 1'b0;
            expire_reg  <= 1'b0;
        end else begin
            expire_reg <= 1'b0;
            if (period_wr) begin
                period_reg <= BUS_DATA_IN;
            end
            if (ctrl_wr) begin
                mode_reg <= BUS_DATA_IN[CTRL_MODE];
            end
            if (done_clear) begin
                done_reg <= 1'b0;
            end

            if (stop_cmd) begin
                state       <= ST_IDLE;
                running_reg <= 1'b0;
            end else if (start_cmd && (state == ST_IDLE) && (period_reg == '0)) begin
                done_reg   <= 1'b1;
                expire_reg <= 1'b1;
            end else if (start_cmd) begin
                state       <= ST_LOAD;
                running_reg <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                    end
                    ST_LOAD: begin
                        if (period_reg == '0) begin
                            count_reg   <= '0;
                            done_reg    <= 1'b1;
                            expire_reg  <= 1'b1;
                            running_reg <= 1'b0;
                            state       <= ST_IDLE;
                        end else begin
                            count_reg <= period_reg;
                            state     <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (tick_now) begin
                            if (count_reg == COUNT_WIDTH'(1)) begin
                                count_reg   <= '0;
                                done_reg    <= 1'b1;
                                expire_reg  <= 1'b1;
                                running_reg <= 1'b0;
                                state       <= ST_DONE;
                            end else if (count_reg != '0) begin
                                count_reg <= count_reg - COUNT_WIDTH'(1);
                            end
                        end
                    end
                    ST_DONE: begin
                        if (mode_reg) begin
                            state       <= ST_LOAD;
                            running_reg <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state       <= ST_IDLE;
                        running_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign EXPIRE_OUT = expire_reg;
    assign RUNNING    = running_reg;

`ifdef TIMER_IRQ_EN
    logic irq_mask_reg;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            irq_mask_reg <= 1'b0;
        end else if (ctrl_wr) begin
            irq_mask_reg <= BUS_DATA_IN[CTRL_IRQ_MASK];
        end
    end

    assign IRQ = done_reg & irq_mask_reg;
`else
    assign IRQ = 1'b0;
`endif

    always_comb begin
        BUS_DATA_OUT = '0;
        case (BUS_ADDR)
            ADDR_CTRL: begin
                BUS_DATA_OUT[CTRL_MODE] = mode_reg;
`ifdef TIMER_IRQ_EN
                BUS_DATA_OUT[CTRL_IRQ_MASK] = irq_mask_reg;
`endif
            end
            ADDR_PERIOD: BUS_DATA_OUT = period_reg;
            ADDR_COUNT:  BUS_DATA_OUT = count_reg;
            ADDR_STATUS: begin
                BUS_DATA_OUT[STATUS_RUNNING] = running_reg;
                BUS_DATA_OUT[STATUS_DONE]    = done_reg;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Bench for interval_timer_ctrl with PRESCALE_MAX=3: directed scenarios plus randomized
// one-shot/periodic runs compared against an arithmetic timing model.
module tb_interval_timer_ctrl;

    localparam int TICKS = 4;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PERIOD = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

`ifdef TIMER_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [1:0]  BUS_ADDR = 2'd0;
    logic        BUS_WE = 1'b0;
    logic [15:0] BUS_DATA_IN = 16'd0;
    logic [15:0] BUS_DATA_OUT;
    logic        TICK_OUT;
    logic        EXPIRE_OUT;
    logic        RUNNING;
    logic        IRQ;

    int checks = 0;
    int errors = 0;

    interval_timer_ctrl #(
        .PRESCALE_WIDTH (17),
        .PRESCALE_MAX   (3),
        .COUNT_WIDTH    (16)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .BUS_ADDR     (BUS_ADDR),
        .BUS_WE       (BUS_WE),
        .BUS_DATA_IN  (BUS_DATA_IN),
        .BUS_DATA_OUT (BUS_DATA_OUT),
        .TICK_OUT     (TICK_OUT),
        .EXPIRE_OUT   (EXPIRE_OUT),
        .RUNNING      (RUNNING),
        .IRQ          (IRQ)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit tick;
        bit expire;
        bit running;
        int count;
        bit count_known;
        bit done;
    } expect_t;

    // c = clock edges since the START write edge (c=0 is the LOAD cycle)
    function automatic expect_t timerModel(input int c, input int p, input bit periodic);
        expect_t e;
        int len;
        int u;
        len = TICKS * p + 2;
        u = periodic ? (c % len) : c;
        e.tick        = (u >= 1 + TICKS) && ((u - 1) % TICKS == 0) && (u <= TICKS * p + 1);
        e.expire      = (u == TICKS * p + 1);
        e.running     = (u <= TICKS * p);
        e.count       = (u >= 1 && u <= TICKS * p + 1) ? (p - (u - 1) / TICKS) : 0;
        e.count_known = (c != 0);
        e.done        = (c >= TICKS * p + 1);
        return e;
    endfunction

    task automatic stepCycle();
        @(negedge CLK);
    endtask

    task automatic applyStimulus(input logic [1:0] addr, input logic [15:0] data);
        BUS_ADDR    = addr;
        BUS_DATA_IN = data;
        BUS_WE      = 1'b1;
        @(negedge CLK);
        BUS_WE = 1'b0;
    endtask

    task automatic readReg(input logic [1:0] addr, output logic [15:0] data);
        BUS_ADDR = addr;
        #1;
        data = BUS_DATA_OUT;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkQuiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            stepCycle();
            checkOutput($sformatf("%s TICK_OUT i=%0d", tag, i), TICK_OUT, 0);
            checkOutput($sformatf("%s EXPIRE_OUT i=%0d", tag, i), EXPIRE_OUT, 0);
            checkOutput($sformatf("%s RUNNING i=%0d", tag, i), RUNNING, 0);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] rd;
        expect_t     e;
        int          p;
        bit          periodic;
        bit          mask;
        int          cmax;

        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        stepCycle();

        $display("[TB] reset state");
        checkOutput("reset TICK_OUT", TICK_OUT, 0);
        checkOutput("reset EXPIRE_OUT", EXPIRE_OUT, 0);
        checkOutput("reset RUNNING", RUNNING, 0);
        checkOutput("reset IRQ", IRQ, 0);
        readReg(A_CTRL, rd);   checkOutput("reset CTRL", rd, 16'h0);
        readReg(A_PERIOD, rd); checkOutput("reset PERIOD", rd, 16'h0);
        readReg(A_COUNT, rd);  checkOutput("reset COUNT", rd, 16'h0);
        readReg(A_STATUS, rd); checkOutput("reset STATUS", rd, 16'h0);
        stepCycle();

        $display("[TB] one-shot PERIOD=3");
        applyStimulus(A_PERIOD, 16'd3);
        applyStimulus(A_CTRL, 16'h0001);
        for (int c = 0; c <= 16; c++) begin
            if (c > 0) stepCycle();
            checkOutput($sformatf("oneshot TICK_OUT c=%0d", c), TICK_OUT, (c == 5 || c == 9 || c == 13));
            checkOutput($sformatf("oneshot EXPIRE_OUT c=%0d", c), EXPIRE_OUT, (c == 13));
            checkOutput($sformatf("oneshot RUNNING c=%0d", c), RUNNING, (c <= 12));
        end
        readReg(A_STATUS, rd); checkOutput("oneshot STATUS", rd, 16'h2);
        readReg(A_COUNT, rd);  checkOutput("oneshot COUNT", rd, 16'h0);
        applyStimulus(A_STATUS, 16'h0002);
        readReg(A_STATUS, rd); checkOutput("clear STATUS", rd, 16'h0);

        $display("[TB] periodic PERIOD=2 then STOP");
        applyStimulus(A_PERIOD, 16'd2);
        applyStimulus(A_CTRL, 16'h0005);
        for (int c = 0; c <= 23; c++) begin
            if (c > 0) stepCycle();
            checkOutput($sformatf("periodic TICK_OUT c=%0d", c), TICK_OUT, (c == 5 || c == 9 || c == 15 || c == 19));
            checkOutput($sformatf("periodic EXPIRE_OUT c=%0d", c), EXPIRE_OUT, (c == 9 || c == 19));
            checkOutput($sformatf("periodic RUNNING c=%0d", c), RUNNING, !(c == 9 || c == 19));
        end
        readReg(A_CTRL, rd); checkOutput("periodic CTRL readback", rd, 16'h4);
        applyStimulus(A_CTRL, 16'h0002);
        checkOutput("stop RUNNING", RUNNING, 0);
        readReg(A_COUNT, rd);  checkOutput("stop COUNT held", rd, 16'd2);
        readReg(A_STATUS, rd); checkOutput("stop STATUS", rd, 16'h2);
        checkQuiet("stopped", 6);
        readReg(A_COUNT, rd);  checkOutput("stop COUNT frozen", rd, 16'd2);

        $display("[TB] PERIOD=0 start");
        applyStimulus(A_STATUS, 16'h0002);
        applyStimulus(A_PERIOD, 16'd0);
        applyStimulus(A_CTRL, 16'h0001);
        checkOutput("zero EXPIRE_OUT", EXPIRE_OUT, 1);
        checkOutput("zero TICK_OUT", TICK_OUT, 0);
        checkOutput("zero RUNNING", RUNNING, 0);
        readReg(A_STATUS, rd); checkOutput("zero STATUS", rd, 16'h2);
        readReg(A_COUNT, rd);  checkOutput("zero COUNT", rd, 16'd2);
        checkQuiet("zero after", 6);

        $display("[TB] START and STOP together");
        applyStimulus(A_STATUS, 16'h0002);
        applyStimulus(A_PERIOD, 16'd3);
        applyStimulus(A_CTRL, 16'h0003);
        checkOutput("startstop RUNNING", RUNNING, 0);
        checkQuiet("startstop", 8);
        readReg(A_STATUS, rd); checkOutput("startstop STATUS", rd, 16'h0);

        $display("[TB] DONE set/clear race");
        applyStimulus(A_PERIOD, 16'd1);
        applyStimulus(A_CTRL, 16'h0001);
        repeat (4) stepCycle();
        checkOutput("race RUNNING before", RUNNING, 1);
        applyStimulus(A_STATUS, 16'h0002);
        checkOutput("race EXPIRE_OUT", EXPIRE_OUT, 1);
        checkOutput("race TICK_OUT", TICK_OUT, 1);
        readReg(A_STATUS, rd); checkOutput("race STATUS set wins", rd, 16'h2);
        applyStimulus(A_STATUS, 16'h0002);
        readReg(A_STATUS, rd); checkOutput("race STATUS cleared", rd, 16'h0);

        $display("[TB] interrupt");
        applyStimulus(A_CTRL, 16'h0009);
        readReg(A_CTRL, rd); checkOutput("irq CTRL readback", rd, IRQ_BUILD ? 16'h8 : 16'h0);
        checkOutput("irq before expiry", IRQ, 0);
        repeat (5) stepCycle();
        checkOutput("irq EXPIRE_OUT", EXPIRE_OUT, 1);
        checkOutput("irq after expiry", IRQ, IRQ_BUILD);
        applyStimulus(A_STATUS, 16'h0002);
        checkOutput("irq after clear", IRQ, 0);

        $display("[TB] randomized runs");
        for (int run = 0; run < 6; run++) begin
            p        = int'($urandom_range(1, 4));
            periodic = 1'($urandom_range(0, 1));
            mask     = 1'($urandom_range(0, 1));
            cmax     = periodic ? 2 * (TICKS * p + 2) + 3 : TICKS * p + 4;
            applyStimulus(A_STATUS, 16'h0002);
            applyStimulus(A_PERIOD, 16'(p));
            applyStimulus(A_CTRL, {12'd0, mask, periodic, 2'b01});
            for (int c = 0; c <= cmax; c++) begin
                if (c > 0) stepCycle();
                e = timerModel(c, p, periodic);
                checkOutput($sformatf("rand%0d p=%0d m=%0d TICK_OUT c=%0d", run, p, periodic, c), TICK_OUT, e.tick);
                checkOutput($sformatf("rand%0d p=%0d m=%0d EXPIRE_OUT c=%0d", run, p, periodic, c), EXPIRE_OUT, e.expire);
                checkOutput($sformatf("rand%0d p=%0d m=%0d RUNNING c=%0d", run, p, periodic, c), RUNNING, e.running);
                checkOutput($sformatf("rand%0d p=%0d m=%0d IRQ c=%0d", run, p, periodic, c), IRQ, IRQ_BUILD && mask && e.done);
                readReg(A_STATUS, rd);
                checkOutput($sformatf("rand%0d p=%0d m=%0d STATUS c=%0d", run, p, periodic, c), rd, {14'd0, e.done, e.running});
                if (e.count_known) begin
                    readReg(A_COUNT, rd);
                    checkOutput($sformatf("rand%0d p=%0d m=%0d COUNT c=%0d", run, p, periodic, c), rd, 16'(e.count));
                end
            end
            applyStimulus(A_CTRL, 16'h0002);
            checkOutput($sformatf("rand%0d stop RUNNING", run), RUNNING, 0);
        end

        $display("[TB] reset mid-run");
        applyStimulus(A_PERIOD, 16'd3);
        applyStimulus(A_CTRL, 16'h0005);
        repeat (3) stepCycle();
        RESET = 1'b1;
        #1;
        checkOutput("midreset TICK_OUT", TICK_OUT, 0);
        checkOutput("midreset EXPIRE_OUT", EXPIRE_OUT, 0);
        checkOutput("midreset RUNNING", RUNNING, 0);
        checkOutput("midreset IRQ", IRQ, 0);
        readReg(A_STATUS, rd); checkOutput("midreset STATUS", rd, 16'h0);
        readReg(A_COUNT, rd);  checkOutput("midreset COUNT", rd, 16'h0);
        readReg(A_PERIOD, rd); checkOutput("midreset PERIOD", rd, 16'h0);
        stepCycle();
        stepCycle();
        RESET = 1'b0;
        checkQuiet("post reset", 12);
        readReg(A_STATUS, rd); checkOutput("post reset STATUS", rd, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
